led_pattern_gen: RTL and testbench

//  Multi-channel LED pattern engine for board status/heartbeat LEDs. From one clock it produces

---
 rtl/led_pkg.sv | 15 +
 rtl/led_tick_gen.sv | 33 +++
 rtl/led_pattern_gen.sv | 153 +++++++++++++++
 tb/tb_led_pattern_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared mode encoding and clock-divider helper for the LED pattern engine.
package led_pkg;

  typedef enum logic [1:0] {
    LED_MODE_BLINK    = 2'd0,
    LED_MODE_RUN      = 2'd1,
    LED_MODE_PINGPONG = 2'd2,
    LED_MODE_BREATH   = 2'd3
  } led_mode_e;

  function automatic int div_ratio(input int clk_fre, input int fre);
    return clk_fre / fre;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Divide-by-DIV tick: combinational 1-cycle tick while cnt==DIV-1, counter wraps there.
// clr forces the count back to 0 on the next edge; no backpressure.
module led_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  if (DIV < 2) begin : g_bad_div
    $error("led_tick_gen: DIV must be >= 2");
  end

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Blink / running-light / ping-pong / PWM-breathing engine for status LEDs.
// leds and step_o are registered and change 1 cycle after the pattern register; no backpressure.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int CLK_FRE        = 50_000_000,
  parameter int STEP_FRE       = 1,
  parameter int DUTY_FRE       = 512,
  parameter int PWM_BITS       = 8,
  parameter int LED_NUM        = 4,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  led_mode_e          mode,
  output logic [LED_NUM-1:0] leds,
  output logic               step_o
);

  localparam int STEP_DIV = div_ratio(CLK_FRE, STEP_FRE);
  localparam int DUTY_DIV = div_ratio(CLK_FRE, DUTY_FRE);
  localparam logic [LED_NUM-1:0]  UNLIT    = {LED_NUM{LED_ACTIVE_LOW}};
  localparam logic [LED_NUM-1:0]  BIT0     = LED_NUM'(1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  if (PWM_BITS < 2 || LED_NUM < 1) begin : g_bad_param
    $error("led_pattern_gen: PWM_BITS must be >= 2 and LED_NUM >= 1");
  end

  led_mode_e           mode_q;
  logic [LED_NUM-1:0]  pattern, pat_nxt, disp;
  logic                pp_up, pp_up_nxt;
  logic [PWM_BITS-1:0] duty, duty_nxt, pwm_cnt;
  logic                br_up, br_up_nxt;
  logic                adv_q;
  logic                restart, clr, adv;
  logic                step_tick, duty_tick;

  assign restart = en && (mode != mode_q);
  assign clr     = !en || restart;
  assign adv     = en && !restart &&
                   ((mode_q == LED_MODE_BREATH) ? duty_tick : step_tick);
  assign disp    = (mode_q == LED_MODE_BREATH) ? {LED_NUM{pwm_cnt < duty}} : pattern;

  led_tick_gen #(.DIV(STEP_DIV)) u_step_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (step_tick)
  );

  led_tick_gen #(.DIV(DUTY_DIV)) u_duty_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (duty_tick)
  );

  function automatic logic [LED_NUM-1:0] init_pat(input led_mode_e m);
    if (LED_NUM > 1 && (m == LED_MODE_RUN || m == LED_MODE_PINGPONG)) begin
      return BIT0;
    end
    return '0;
  endfunction

  // An all-zero pattern in RUN/PINGPONG means "enabled but not yet stepped":
  // the first tick after en rises lights bit0.
  always_comb begin
    pat_nxt   = pattern;
    pp_up_nxt = pp_up;
    duty_nxt  = duty;
    br_up_nxt = br_up;
    case (mode_q)
      LED_MODE_BLINK: pat_nxt = ~pattern;
      LED_MODE_RUN: begin
        if (LED_NUM == 1)         pat_nxt = ~pattern;
        else if (pattern == '0)   pat_nxt = BIT0;
        else                      pat_nxt = (pattern << 1) | (pattern >> (LED_NUM - 1));
      end
      LED_MODE_PINGPONG: begin
        if (LED_NUM == 1) begin
          pat_nxt = ~pattern;
        end else if (pattern == '0) begin
          pat_nxt   = BIT0;
          pp_up_nxt = 1'b1;
        end else if (pp_up) begin
          pat_nxt   = pattern << 1;
          pp_up_nxt = !pat_nxt[LED_NUM-1];
        end else begin
          pat_nxt   = pattern >> 1;
          pp_up_nxt = pat_nxt[0];
        end
      end
      default: begin
        if (br_up) begin
          if (duty == DUTY_MAX) begin
            duty_nxt  = duty - 1'b1;
            br_up_nxt = 1'b0;
          end else begin
            duty_nxt  = duty + 1'b1;
          end
        end else if (duty == '0) begin
          duty_nxt  = duty + 1'b1;
          br_up_nxt = 1'b1;
        end else begin
          duty_nxt  = duty - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= LED_MODE_BLINK;
      pattern <= '0;
      pp_up   <= 1'b1;
      duty    <= '0;
      br_up   <= 1'b1;
      pwm_cnt <= '0;
      adv_q   <= 1'b0;
      step_o  <= 1'b0;
      leds    <= UNLIT;
    end else begin
      mode_q <= mode;
      leds   <= en ? (disp ^ UNLIT) : UNLIT;
      adv_q  <= adv;
      step_o <= en && adv_q;
      if (!en) begin
        pattern <= '0;
        pp_up   <= 1'b1;
        duty    <= '0;
        br_up   <= 1'b1;
        pwm_cnt <= '0;
      end else if (restart) begin
        pattern <= init_pat(mode);
        pp_up   <= 1'b1;
        duty    <= '0;
        br_up   <= 1'b1;
        pwm_cnt <= '0;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
        if (adv) begin
          pattern <= pat_nxt;
          pp_up   <= pp_up_nxt;
          duty    <= duty_nxt;
          br_up   <= br_up_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a step-index model of the
// patterns; a monitor pops and compares against an active-high and an active-low instance.
module tb_led_pattern_gen;
  import led_pkg::*;

  localparam int CLK_FRE  = 100;
  localparam int STEP_FRE = 10;
  localparam int DUTY_FRE = 50;
  localparam int PWM_BITS = 3;
  localparam int LED_NUM  = 4;
  localparam int STEP_DIV = CLK_FRE / STEP_FRE;
  localparam int DUTY_DIV = CLK_FRE / DUTY_FRE;
  localparam int PWM_M    = 1 << PWM_BITS;
  localparam logic [LED_NUM-1:0] ALL = '1;

  logic clk   = 1'b1;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  led_mode_e mode = LED_MODE_RUN;
  logic [LED_NUM-1:0] leds_h, leds_l;
  logic step_h, step_l;

  always #5 clk = ~clk;

  led_pattern_gen #(.CLK_FRE(CLK_FRE), .STEP_FRE(STEP_FRE), .DUTY_FRE(DUTY_FRE),
                    .PWM_BITS(PWM_BITS), .LED_NUM(LED_NUM), .LED_ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .leds(leds_h), .step_o(step_h));

  led_pattern_gen #(.CLK_FRE(CLK_FRE), .STEP_FRE(STEP_FRE), .DUTY_FRE(DUTY_FRE),
                    .PWM_BITS(PWM_BITS), .LED_NUM(LED_NUM), .LED_ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .leds(leds_l), .step_o(step_l));

  typedef struct packed {
    logic [LED_NUM-1:0] leds;
    logic               step;
  } exp_t;

  exp_t               expq[$];
  logic [LED_NUM-1:0] stepq[$];
  int chk_total = 0;
  int chk_pass  = 0;

  // Model state: steps taken since the last restart, plus the tick/pwm phase.
  int m_mq, m_cnt, m_k, m_pwm;
  bit m_blank, m_tickq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    chk_total++;
    if (act === want) chk_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, want);
  endtask

  function automatic void model_reset();
    m_mq = 0; m_cnt = 0; m_k = 0; m_pwm = 0; m_blank = 1'b1; m_tickq = 1'b0;
  endfunction

  // Lit pattern after k steps. A restart caused by en leaves the LEDs dark until the first
  // step (blank), a mode change shows the mode's first pattern straight away.
  function automatic logic [LED_NUM-1:0] model_pat(input int mq, input int k, input bit blank,
                                                   input int pwm);
    int s, p, duty;
    logic [LED_NUM-1:0] one, res;
    one = '0;
    one[0] = 1'b1;
    res = '0;
    s = blank ? k - 1 : k;
    case (mq)
      0: res = (k % 2 == 1) ? ALL : '0;
      1: if (s >= 0) res = one << (s % LED_NUM);
      2: if (s >= 0) begin
        p = s % (2 * LED_NUM - 2);
        res = one << ((p < LED_NUM) ? p : 2 * LED_NUM - 2 - p);
      end
      default: begin
        p = k % (2 * PWM_M - 2);
        duty = (p < PWM_M) ? p : 2 * PWM_M - 2 - p;
        res = (pwm < duty) ? ALL : '0;
      end
    endcase
    return res;
  endfunction

  task automatic drive(input bit r, input bit e, input led_mode_e md);
    exp_t x;
    int div;
    bit t;
    @(negedge clk);
    rst_n = r;
    en    = e;
    mode  = md;
    if (!r) begin
      x.leds = '0;
      x.step = 1'b0;
      model_reset();
    end else begin
      x.leds = e ? model_pat(m_mq, m_k, m_blank, m_pwm) : '0;
      x.step = e && m_tickq;
      if (!e) begin
        m_cnt = 0; m_k = 0; m_blank = 1'b1; m_tickq = 1'b0; m_pwm = 0;
      end else if (int'(md) != m_mq) begin
        m_cnt = 0; m_k = 0; m_blank = 1'b0; m_tickq = 1'b0; m_pwm = 0;
      end else begin
        div = (m_mq == 3) ? DUTY_DIV : STEP_DIV;
        t = (m_cnt == div - 1);
        m_cnt = t ? 0 : m_cnt + 1;
        if (t) m_k++;
        m_tickq = t;
        m_pwm = (m_pwm + 1) % PWM_M;
      end
      m_mq = int'(md);
    end
    expq.push_back(x);
    if (x.step) stepq.push_back(x.leds);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_leds_h", leds_h, '0);
    check("arst_leds_l", leds_l, ALL);
    check("arst_step_h", step_h, 1'b0);
    check("arst_step_l", step_l, 1'b0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() == 0) begin
        chk_total++;
        $display("FAIL scoreboard_empty @%0t: no expected entry for this cycle", $time);
      end else begin
        x = expq.pop_front();
        check("leds_h", leds_h, x.leds);
        check("leds_l", leds_l, x.leds ^ ALL);
        check("step_h", step_h, x.step);
        check("step_l", step_l, x.step);
      end
      if (step_h) begin
        if (stepq.size() == 0) begin
          chk_total++;
          $display("FAIL step_unexpected @%0t: step_o with leds %0h, expected no step", $time, leds_h);
        end else begin
          check("step_leds", leds_h, stepq.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    led_mode_e md;
    model_reset();
    // Reset, then enable RUN with mode already settled: dark until the first step.
    repeat (3)  drive(1'b0, 1'b0, LED_MODE_RUN);
    repeat (3)  drive(1'b1, 1'b0, LED_MODE_RUN);
    repeat (55) drive(1'b1, 1'b1, LED_MODE_RUN);
    repeat (95) drive(1'b1, 1'b1, LED_MODE_PINGPONG);
    repeat (40) drive(1'b1, 1'b1, LED_MODE_BREATH);
    // RUN -> BLINK landing exactly on a step tick.
    repeat (23) drive(1'b1, 1'b1, LED_MODE_RUN);
    n = 0;
    while (m_cnt != STEP_DIV - 1 && n < 40) begin
      drive(1'b1, 1'b1, LED_MODE_RUN);
      n++;
    end
    repeat (31) drive(1'b1, 1'b1, LED_MODE_BLINK);
    // One-cycle en drop mid-count.
    repeat (7)  drive(1'b1, 1'b1, LED_MODE_BLINK);
    drive(1'b1, 1'b0, LED_MODE_BLINK);
    repeat (25) drive(1'b1, 1'b1, LED_MODE_BLINK);
    // Asynchronous reset between edges during BREATH.
    repeat (13) drive(1'b1, 1'b1, LED_MODE_BREATH);
    async_reset();
    repeat (2)  drive(1'b0, 1'b1, LED_MODE_BREATH);
    repeat (40) drive(1'b1, 1'b1, LED_MODE_BREATH);
    // Random en drops and mode changes.
    md = LED_MODE_PINGPONG;
    repeat (700) begin
      if ($urandom_range(0, 29) == 0) md = led_mode_e'($urandom_range(0, 3));
      drive(1'b1, ($urandom_range(0, 99) >= 3), md);
    end
    @(posedge clk);
    #2;
    check("step_drain", stepq.size(), 0);
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
